// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared field widths, IEEE constants and FSM states for the fp32 divider
package fp32_pkg;

  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int BIAS      = 127;
  localparam int DIV_STEPS = 26;

  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF   = 32'h7F80_0000;
  localparam logic [31:0] QUIET_BIT = 32'h0040_0000;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/fp32_classify.sv
// rtl/fp32_classify.sv - combinational operand decode: zero/inf/nan, sign, exponent, significand
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0]       x,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan,
  output logic              sign,
  output logic [EXP_W-1:0]  exp_f,
  output logic [FRAC_W:0]   sig
);

  // Exponent 0 is treated as zero, so subnormals are flushed here.
  always_comb begin
    sign    = x[31];
    exp_f   = x[30:23];
    is_zero = (x[30:23] == '0);
    is_inf  = (x[30:23] == '1) && (x[22:0] == '0);
    is_nan  = (x[30:23] == '1) && (x[22:0] != '0);
    sig     = is_zero ? '0 : {1'b1, x[22:0]};
  end

endmodule

// File: rtl/fp32_divider.sv
// rtl/fp32_divider.sv - fp32 divider: restoring radix-2, RNE rounding, valid/ready handshake
// Optional: FP32_DIV_DBZ_EN adds the Div_By_Zero output for nonzero-finite/0.
module fp32_divider
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] Out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        Invalid_Num
`ifdef FP32_DIV_DBZ_EN
  , output logic      Div_By_Zero
`endif
);

  state_t             state, state_nxt;
  logic [4:0]         cnt;
  logic [23:0]        div_d;
  logic [24:0]        rem;
  logic [25:0]        quo;
  logic signed [9:0]  exp_r;
  logic               sign_r;

  logic               ca_zero, ca_inf, ca_nan, ca_sign;
  logic               cb_zero, cb_inf, cb_nan, cb_sign;
  logic [EXP_W-1:0]   ca_exp, cb_exp;
  logic [FRAC_W:0]    ca_sig, cb_sig;

  fp32_classify u_cls_a (
    .x(A), .is_zero(ca_zero), .is_inf(ca_inf), .is_nan(ca_nan),
    .sign(ca_sign), .exp_f(ca_exp), .sig(ca_sig)
  );

  fp32_classify u_cls_b (
    .x(B), .is_zero(cb_zero), .is_inf(cb_inf), .is_nan(cb_nan),
    .sign(cb_sign), .exp_f(cb_exp), .sig(cb_sig)
  );

  assign in_ready = (state == IDLE);

  logic        res_sign;
  logic        spec_hit;
  logic [31:0] spec_out;
  logic        spec_inv;
`ifdef FP32_DIV_DBZ_EN
  logic        spec_dbz;
`endif

  // Special operands resolved straight from the live inputs, in priority order.
  always_comb begin
    res_sign = ca_sign ^ cb_sign;
    spec_hit = 1'b1;
    spec_out = '0;
    spec_inv = 1'b0;
`ifdef FP32_DIV_DBZ_EN
    spec_dbz = 1'b0;
`endif
    if (ca_nan) begin
      spec_out = A | QUIET_BIT;
      spec_inv = 1'b1;
    end else if (cb_nan) begin
      spec_out = B | QUIET_BIT;
      spec_inv = 1'b1;
    end else if ((ca_zero && cb_zero) || (ca_inf && cb_inf)) begin
      spec_out = QNAN;
      spec_inv = 1'b1;
    end else if (ca_inf) begin
      spec_out = {res_sign, POS_INF[30:0]};
      spec_inv = 1'b1;
    end else if (cb_inf) begin
      spec_out = {res_sign, 31'b0};
      spec_inv = 1'b1;
    end else if (ca_zero) begin
      spec_out = {res_sign, 31'b0};
    end else if (cb_zero) begin
      spec_out = {res_sign, POS_INF[30:0]};
`ifdef FP32_DIV_DBZ_EN
      spec_dbz = 1'b1;
`else
      spec_inv = 1'b1;
`endif
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic        q_bit;
  logic [23:0] rem_sub;

  // One restoring step: subtract the divisor when it fits, keep the remainder otherwise.
  always_comb begin
    q_bit   = (rem >= {1'b0, div_d});
    rem_sub = q_bit ? 24'(rem - {1'b0, div_d}) : rem[23:0];
  end

  logic              norm, guard, sticky, round_up;
  logic [23:0]       mant;
  logic [24:0]       mant_rnd;
  logic signed [9:0] exp_fin;
  logic [31:0]       rnd_out;

  // Normalize the 26-bit quotient, round to nearest even, then saturate or flush.
  always_comb begin
    norm     = quo[25];
    mant     = norm ? quo[25:2] : quo[24:1];
    guard    = norm ? quo[1] : quo[0];
    sticky   = (norm & quo[0]) | (rem != '0);
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {24'b0, round_up};
    exp_fin  = exp_r - {9'b0, ~norm} + {9'b0, mant_rnd[24]};
    rnd_out  = {sign_r, exp_fin[7:0], mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0]};
    if (exp_fin >= 10'sd255) begin
      rnd_out = {sign_r, POS_INF[30:0]};
    end else if (exp_fin <= 10'sd0) begin
      rnd_out = {sign_r, 31'b0};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: specials skip straight to DONE, normal operands divide then round.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = spec_hit ? DONE : DIV;
      DIV:     if (cnt == 5'(DIV_STEPS - 1)) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and result registers; Out and flags only change when a new result lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      div_d       <= '0;
      rem         <= '0;
      quo         <= '0;
      exp_r       <= '0;
      sign_r      <= 1'b0;
      Out         <= '0;
      out_valid   <= 1'b0;
      Invalid_Num <= 1'b0;
`ifdef FP32_DIV_DBZ_EN
      Div_By_Zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r <= res_sign;
            exp_r  <= {2'b00, ca_exp} - {2'b00, cb_exp} + 10'(BIAS);
            rem    <= {1'b0, ca_sig};
            div_d  <= cb_sig;
            quo    <= '0;
            cnt    <= '0;
            if (spec_hit) begin
              Out         <= spec_out;
              Invalid_Num <= spec_inv;
`ifdef FP32_DIV_DBZ_EN
              Div_By_Zero <= spec_dbz;
`endif
            end
          end
        end
        DIV: begin
          rem <= {rem_sub, 1'b0};
          quo <= {quo[24:0], q_bit};
          cnt <= cnt + 5'd1;
        end
        ROUND: begin
          Out         <= rnd_out;
          Invalid_Num <= 1'b0;
`ifdef FP32_DIV_DBZ_EN
          Div_By_Zero <= 1'b0;
`endif
        end
        DONE: begin
          if (!out_valid)     out_valid <= 1'b1;
          else if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_divider.sv
// tb/tb_fp32_divider.sv - scoreboard bench for fp32_divider (honours FP32_DIV_DBZ_EN)
module tb_fp32_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B, Out;
  logic        in_valid, in_ready, out_valid, out_ready, Invalid_Num;
`ifdef FP32_DIV_DBZ_EN
  logic        Div_By_Zero;
  localparam bit DBZ = 1'b1;
`else
  localparam bit DBZ = 1'b0;
`endif

  always #5 clk = ~clk;

  fp32_divider dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid), .in_ready(in_ready),
    .Out(Out), .out_valid(out_valid), .out_ready(out_ready), .Invalid_Num(Invalid_Num)
`ifdef FP32_DIV_DBZ_EN
    , .Div_By_Zero(Div_By_Zero)
`endif
  );

  typedef struct {
    logic [31:0] out;
    logic        inv;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  localparam int NN = 8;
  localparam logic [31:0] NA [NN] = '{32'h40C00000, 32'h3F800000, 32'h7F000000, 32'hC1200000,
                                      32'h3F800000, 32'h40000000, 32'h00800000, 32'h3F800000};
  localparam logic [31:0] NB [NN] = '{32'h40000000, 32'h40400000, 32'h3E800000, 32'h40000000,
                                      32'h3F800000, 32'h40400000, 32'h7F000000, 32'hBFC00000};
  localparam logic [31:0] NQ [NN] = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'hC0A00000,
                                      32'h3F800000, 32'h3F2AAAAB, 32'h00000000, 32'hBF2AAAAB};

  localparam int NS = 12;
  localparam logic [31:0] SA [NS] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F800001,
                                      32'h3F800000, 32'h7F800000, 32'h7F800000, 32'h40400000,
                                      32'h80000000, 32'h00000001, 32'h7F800000, 32'h00000000};
  localparam logic [31:0] SB [NS] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h3F800000,
                                      32'hFF800005, 32'hFF800000, 32'hC0000000, 32'hFF800000,
                                      32'h40A00000, 32'h3F800000, 32'h00000000, 32'h7F800000};
  localparam logic [31:0] SQ [NS] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7FC00001,
                                      32'hFFC00005, 32'h7FC00000, 32'hFF800000, 32'h80000000,
                                      32'h80000000, 32'h00000000, 32'h7F800000, 32'h00000000};
  localparam bit SI [NS] = '{!DBZ, !DBZ, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam bit SD [NS] = '{DBZ, DBZ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                       input logic inv, input logic dbz, input int lat);
    exp_t e;
    e.out = q; e.inv = inv; e.dbz = dbz; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(output logic [31:0] o, output logic inv, output logic dbz, output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    o = Out; inv = Invalid_Num;
`ifdef FP32_DIV_DBZ_EN
    dbz = Div_By_Zero;
`else
    dbz = 1'b0;
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0; A = '0; B = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (Out !== 32'h0) begin n_err++; $display("FAIL reset Out: got %h expected 0", Out); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (Invalid_Num !== 1'b0) begin n_err++; $display("FAIL reset Invalid_Num: got %b expected 0", Invalid_Num); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal;
    logic [31:0] o; logic inv, dbz; int lat; exp_t e;
    for (int i = 0; i < NN; i++) begin
      issue(NA[i], NB[i], NQ[i], 1'b0, 1'b0, 28);
      collect(o, inv, dbz, lat);
      e = sb.pop_front();
      n_cmp++; if (o !== e.out) begin n_err++; $display("FAIL normal[%0d] Out: got %h expected %h", i, o, e.out); end
      n_cmp++; if (inv !== e.inv) begin n_err++; $display("FAIL normal[%0d] Invalid_Num: got %b expected %b", i, inv, e.inv); end
      n_cmp++; if (dbz !== e.dbz) begin n_err++; $display("FAIL normal[%0d] Div_By_Zero: got %b expected %b", i, dbz, e.dbz); end
      n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL normal[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_special;
    logic [31:0] o; logic inv, dbz; int lat; exp_t e;
    for (int i = 0; i < NS; i++) begin
      issue(SA[i], SB[i], SQ[i], SI[i], SD[i], 1);
      collect(o, inv, dbz, lat);
      e = sb.pop_front();
      n_cmp++; if (o !== e.out) begin n_err++; $display("FAIL special[%0d] Out: got %h expected %h", i, o, e.out); end
      n_cmp++; if (inv !== e.inv) begin n_err++; $display("FAIL special[%0d] Invalid_Num: got %b expected %b", i, inv, e.inv); end
      n_cmp++; if (dbz !== e.dbz) begin n_err++; $display("FAIL special[%0d] Div_By_Zero: got %b expected %b", i, dbz, e.dbz); end
      n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL special[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] o; logic inv, dbz; int lat; exp_t e;
    out_ready = 1'b0;
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 28);
    collect(o, inv, dbz, lat);
    e = sb.pop_front();
    n_cmp++; if (o !== e.out) begin n_err++; $display("FAIL bp Out: got %h expected %h", o, e.out); end
    n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL bp latency: got %0d expected %0d", lat, e.lat); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      A = 32'h3F800000; B = 32'h3F800000; in_valid = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (Out !== e.out) begin n_err++; $display("FAIL bp hold[%0d] Out: got %h expected %h", c, Out, e.out); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp hold[%0d] out_valid: got %b expected 1", c, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp hold[%0d] in_ready: got %b expected 0", c, in_ready); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp release out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp release in_ready: got %b expected 1", in_ready); end
    e.out = 32'h3F800000; e.inv = 1'b0; e.dbz = 1'b0; e.lat = 28;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    collect(o, inv, dbz, lat);
    e = sb.pop_front();
    n_cmp++; if (o !== e.out) begin n_err++; $display("FAIL bp next Out: got %h expected %h", o, e.out); end
    n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL bp next latency: got %0d expected %0d", lat, e.lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_div;
    logic [31:0] o; logic inv, dbz; int lat; exp_t e;
    issue(32'h3F800000, 32'h00000000, 32'h7F800000, !DBZ, DBZ, 1);
    collect(o, inv, dbz, lat);
    e = sb.pop_front();
    n_cmp++; if (o !== e.out) begin n_err++; $display("FAIL rst pre Out: got %h expected %h", o, e.out); end
    @(posedge clk); #1;
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 28);
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    n_cmp++; if (Out !== 32'h0) begin n_err++; $display("FAIL rst mid Out: got %h expected 0", Out); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst mid out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (Invalid_Num !== 1'b0) begin n_err++; $display("FAIL rst mid Invalid_Num: got %b expected 0", Invalid_Num); end
`ifdef FP32_DIV_DBZ_EN
    n_cmp++; if (Div_By_Zero !== 1'b0) begin n_err++; $display("FAIL rst mid Div_By_Zero: got %b expected 0", Div_By_Zero); end
`endif
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst mid in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 28);
    collect(o, inv, dbz, lat);
    e = sb.pop_front();
    n_cmp++; if (o !== e.out) begin n_err++; $display("FAIL rst post Out: got %h expected %h", o, e.out); end
    n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL rst post latency: got %0d expected %0d", lat, e.lat); end
    n_cmp++; if (inv !== e.inv) begin n_err++; $display("FAIL rst post Invalid_Num: got %b expected %b", inv, e.inv); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_backpressure();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp32_divider.md
FP32_DIVIDER -- requirements
Module: fp32_divider

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-003 SHALL have port A, input, 32, IEEE-754 single dividend.
REQ-004 SHALL have port B, input, 32, IEEE-754 single divisor.
REQ-005 SHALL have port in_valid, input, 1, A/B valid.
REQ-006 SHALL have port in_ready, output, 1, high only in IDLE.
REQ-007 SHALL have port Out, output, 32, quotient A/B; held stable while out_valid.
REQ-008 SHALL have port out_valid, output, 1, Out and flags valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port Invalid_Num, output, 1, NaN or Inf operand, or invalid operation.
REQ-011 SHALL have port Div_By_Zero, output, 1, finite nonzero A with zero B; present only under FP32_DIV_DBZ_EN.

Function
REQ-012 SHALL implement states IDLE, DIV, ROUND, DONE.
REQ-013 SHALL accept operands on the edge where in_valid and in_ready are both high, registering A and B.
REQ-014 SHALL treat exponent 0 as zero, flushing subnormal inputs; NaN is exponent 255 with nonzero fraction.
REQ-015 SHALL resolve special cases at acceptance, IDLE->DONE, out_valid one cycle later, in priority order below.
REQ-016 SHALL return A with the quiet bit (bit 22) set if A is NaN, else B likewise if B is NaN; Invalid_Num=1.
REQ-017 SHALL return 0x7FC00000 with Invalid_Num=1 for 0/0 and Inf/Inf.
REQ-018 SHALL return signed Inf for Inf/finite and signed zero for finite/Inf, with Invalid_Num=1.
REQ-019 SHALL return signed zero for 0/nonzero with Invalid_Num=0.
REQ-020 SHALL return signed Inf for nonzero/0.
REQ-021 SHALL compute sign as A[31]^B[31] for every non-NaN result.
REQ-022 SHALL otherwise run restoring radix-2 division of {1,A[22:0]} by {1,B[22:0]} in DIV, one quotient bit per cycle, exactly 26 cycles.
REQ-023 SHALL compute the exponent as a 10-bit signed value EA-EB+127, decremented by 1 when the quotient integer bit is 0 (normalize left by 1).
REQ-024 SHALL round to nearest, ties-to-even, in ROUND (1 cycle), using guard bit and sticky (any nonzero remainder or lower bit); mantissa carry-out increments the exponent.
REQ-025 SHALL saturate final exponent >=255 to signed Inf and flush final exponent <=0 to signed zero, with Invalid_Num=0.
REQ-026 SHALL assert out_valid in DONE exactly 28 edges after acceptance for the normal path.
REQ-027 SHALL hold Out, flags and out_valid in DONE until out_ready is high; that edge returns to IDLE.
REQ-028 SHALL ignore in_valid outside IDLE; no back-to-back acceptance on the DONE->IDLE edge.

Reset
REQ-029 SHALL on rst_n low, including mid-DIV, immediately force state IDLE, Out=0, out_valid=0, Invalid_Num=0, Div_By_Zero=0, iteration counter 0, and in_ready=1.

Configuration
REQ-030 SHALL, with FP32_DIV_DBZ_EN defined, expose Div_By_Zero=1 for nonzero-finite/0, Invalid_Num=0.
REQ-031 SHALL, without FP32_DIV_DBZ_EN, omit the port and signal nonzero/0 via Invalid_Num=1; Out unchanged.

Structure
REQ-032 SHALL take field widths, bias 127, QNAN 0x7FC00000, POS_INF 0x7F800000 and the state enum from shared package fp32_pkg.
REQ-033 SHALL instantiate one combinational sub-module fp32_classify (per operand: is_zero, is_inf, is_nan, sign, exponent, significand).

Verification
REQ-034 SHALL check 0x40C00000 / 0x40000000 -> Out=0x40400000, out_valid exactly 28 cycles after acceptance, flags 0.
REQ-035 SHALL check 0x3F800000 / 0x40400000 -> 0x3EAAAAAB (rounding up via sticky).
REQ-036 SHALL check 0x3F800000 / 0x00000000 -> 0x7F800000 after 1 cycle; Div_By_Zero=1 (macro on) or Invalid_Num=1 (macro off).
REQ-037 SHALL check 0x00000000 / 0x00000000 -> 0x7FC00000, Invalid_Num=1; 0x7F000000 / 0x3E800000 -> 0x7F800000, Invalid_Num=0.
REQ-038 SHALL check out_ready low 10 cycles in DONE -> Out stable, in_ready=0, in_valid ignored; accept on out_ready rise.
REQ-039 SHALL check rst_n low at DIV cycle 12 -> all outputs 0, in_ready=1; next operation gives correct result.
